// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search sequencer: FSM states, S-RAM owner phases, widths.
// Pure declarations; no logic, no latency, no flow control.
package rc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int KEY_W    = 24;

  typedef enum logic [3:0] {
    IDLE,
    INIT_RUN,
    INIT_ACK,
    SHUF_RUN,
    SHUF_ACK,
    DEC_RUN,
    DEC_ACK,
    NEXT_KEY,
    FOUND,
    FAILED
  } rc4_seq_state_t;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_INIT,
    PH_SHUF,
    PH_DEC
  } rc4_phase_t;

  // The S-RAM owner is a pure function of the FSM state, including the ack cycle.
  function automatic rc4_phase_t phase_of(input rc4_seq_state_t s);
    case (s)
      INIT_RUN, INIT_ACK: return PH_INIT;
      SHUF_RUN, SHUF_ACK: return PH_SHUF;
      DEC_RUN,  DEC_ACK:  return PH_DEC;
      default:            return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_s_port_mux.sv
// Shared S-RAM port selector: routes the owning engine's addr/data/wren, zeros when unowned.
// Purely combinational, zero latency; no backpressure (engines own the port for whole phases).
module rc4_s_port_mux
  import rc4_pkg::*;
(
  input  rc4_phase_t            phase,
  input  logic [S_ADDR_W-1:0]   init_addr,
  input  logic [S_DATA_W-1:0]   init_data,
  input  logic                  init_wren,
  input  logic [S_ADDR_W-1:0]   shuf_addr,
  input  logic [S_DATA_W-1:0]   shuf_data,
  input  logic                  shuf_wren,
  input  logic [S_ADDR_W-1:0]   dec_addr,
  input  logic [S_DATA_W-1:0]   dec_data,
  input  logic                  dec_wren,
  output logic [S_ADDR_W-1:0]   s_addr,
  output logic [S_DATA_W-1:0]   s_data,
  output logic                  s_wren
);

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wren = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      PH_SHUF: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
      end
      PH_DEC: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs init -> shuffle -> decrypt per key, stepping the key until a hit or KEY_MAX; 2 cycles overhead per phase.
// Start/ack pulses are registered one-cycle strobes; engines hold finish until acked.
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int               KEY_W   = 24,
  parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                init_start,
  output logic                shuf_start,
  output logic                dec_start,
  input  logic                init_finish,
  input  logic                shuf_finish,
  input  logic                dec_finish,
  output logic                init_ack,
  output logic                shuf_ack,
  output logic                dec_ack,
  input  logic                dec_key_ok,
  input  logic [S_ADDR_W-1:0] init_addr,
  input  logic [S_DATA_W-1:0] init_data,
  input  logic                init_wren,
  input  logic [S_ADDR_W-1:0] shuf_addr,
  input  logic [S_DATA_W-1:0] shuf_data,
  input  logic                shuf_wren,
  input  logic [S_ADDR_W-1:0] dec_addr,
  input  logic [S_DATA_W-1:0] dec_data,
  input  logic                dec_wren,
  output logic [S_ADDR_W-1:0] s_addr,
  output logic [S_DATA_W-1:0] s_data,
  output logic                s_wren,
  output logic [KEY_W-1:0]    secret_key,
  output logic                busy,
  output logic                found,
  output logic                failed
);

  rc4_seq_state_t   state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             verdict_q, verdict_d;
  logic             found_q, found_d;
  logic             failed_q, failed_d;
  logic [2:0]       start_q, start_d;   // {dec, shuf, init}
  logic [2:0]       ack_q, ack_d;
  rc4_phase_t       phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_q     <= '0;
      verdict_q <= 1'b0;
      found_q   <= 1'b0;
      failed_q  <= 1'b0;
      start_q   <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      verdict_q <= verdict_d;
      found_q   <= found_d;
      failed_q  <= failed_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
    end
  end

  // Pulses are decided alongside the transition so they land in the first cycle of the new state.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    verdict_d = verdict_q;
    found_d   = found_q;
    failed_d  = failed_q;
    start_d   = '0;
    ack_d     = '0;
    case (state_q)
      IDLE, FOUND, FAILED: begin
        if (start) begin
          state_d    = INIT_RUN;
          key_d      = '0;
          found_d    = 1'b0;
          failed_d   = 1'b0;
          start_d[0] = 1'b1;
        end
      end
      INIT_RUN: begin
        if (init_finish) begin
          state_d  = INIT_ACK;
          ack_d[0] = 1'b1;
        end
      end
      INIT_ACK: begin
        state_d    = SHUF_RUN;
        start_d[1] = 1'b1;
      end
      SHUF_RUN: begin
        if (shuf_finish) begin
          state_d  = SHUF_ACK;
          ack_d[1] = 1'b1;
        end
      end
      SHUF_ACK: begin
        state_d    = DEC_RUN;
        start_d[2] = 1'b1;
      end
      DEC_RUN: begin
        if (dec_finish) begin
          state_d   = DEC_ACK;
          ack_d[2]  = 1'b1;
          verdict_d = dec_key_ok;
        end
      end
      DEC_ACK: begin
        if (verdict_q) begin
          state_d = FOUND;
          found_d = 1'b1;
        end else begin
          state_d = NEXT_KEY;
        end
      end
      NEXT_KEY: begin
        if (key_q == KEY_MAX) begin
          state_d  = FAILED;
          failed_d = 1'b1;
        end else begin
          state_d    = INIT_RUN;
          key_d      = key_q + KEY_W'(1);
          start_d[0] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = !(state_q inside {IDLE, FOUND, FAILED});
    phase      = phase_of(state_q);
    init_start = start_q[0];
    shuf_start = start_q[1];
    dec_start  = start_q[2];
    init_ack   = ack_q[0];
    shuf_ack   = ack_q[1];
    dec_ack    = ack_q[2];
    secret_key = key_q;
    found      = found_q;
    failed     = failed_q;
  end

  rc4_s_port_mux u_s_port_mux (
    .phase     (phase),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_wren (init_wren),
    .shuf_addr (shuf_addr),
    .shuf_data (shuf_data),
    .shuf_wren (shuf_wren),
    .dec_addr  (dec_addr),
    .dec_data  (dec_data),
    .dec_wren  (dec_wren),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .s_wren    (s_wren)
  );

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench: two sequencers (default KEY_MAX and KEY_MAX=2) driven by 5-cycle stub engines,
// with an event scoreboard on start pulses and search results.
module tb_rc4_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_i [2];
  wire  [2:0]  st [2];
  wire  [2:0]  ak [2];
  logic [2:0]  fin_q [2];
  logic [2:0]  run_q [2];
  logic [3:0]  cnt_q [2][3];
  logic        xfin [2];
  logic        ovr;
  logic [23:0] ok_key [2];
  logic        ok_en [2];
  wire  [2:0]  finw [2];
  wire  [7:0]  ea [2][3];
  wire  [7:0]  ed [2][3];
  wire  [2:0]  ew [2];
  wire  [7:0]  s_addr [2];
  wire  [7:0]  s_data [2];
  wire         s_wren [2];
  wire  [23:0] key [2];
  wire         busy [2];
  wire         found [2];
  wire         failed [2];
  wire         key_ok [2];

  for (genvar u = 0; u < 2; u++) begin : g_unit
    assign finw[u]   = fin_q[u] | {2'b00, xfin[u]};
    assign key_ok[u] = ok_en[u] && (key[u] == ok_key[u]);
    for (genvar e = 0; e < 3; e++) begin : g_eng
      localparam bit STRAY = (u == 0) && (e == 1);
      assign ea[u][e] = (STRAY && ovr) ? 8'h55 : {2'(e + 1), 2'b00, cnt_q[u][e]};
      assign ed[u][e] = 8'hA0 + 8'(e);
      assign ew[u][e] = run_q[u][e] | (STRAY && ovr);
    end
  end

  // Stub engines: run 5 cycles after start, then hold finish until acked.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        fin_q[u] <= '0;
        run_q[u] <= '0;
        for (int e = 0; e < 3; e++) cnt_q[u][e] <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        for (int e = 0; e < 3; e++) begin
          if (st[u][e]) begin
            run_q[u][e] <= 1'b1;
            cnt_q[u][e] <= '0;
          end else if (run_q[u][e]) begin
            cnt_q[u][e] <= cnt_q[u][e] + 4'd1;
            if (cnt_q[u][e] == 4'd4) begin
              run_q[u][e] <= 1'b0;
              fin_q[u][e] <= 1'b1;
            end
          end
          if (fin_q[u][e] && ak[u][e]) fin_q[u][e] <= 1'b0;
        end
      end
    end
  end

  rc4_phase_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]),
    .init_start(st[0][0]), .shuf_start(st[0][1]), .dec_start(st[0][2]),
    .init_finish(finw[0][0]), .shuf_finish(finw[0][1]), .dec_finish(finw[0][2]),
    .init_ack(ak[0][0]), .shuf_ack(ak[0][1]), .dec_ack(ak[0][2]),
    .dec_key_ok(key_ok[0]),
    .init_addr(ea[0][0]), .init_data(ed[0][0]), .init_wren(ew[0][0]),
    .shuf_addr(ea[0][1]), .shuf_data(ed[0][1]), .shuf_wren(ew[0][1]),
    .dec_addr(ea[0][2]), .dec_data(ed[0][2]), .dec_wren(ew[0][2]),
    .s_addr(s_addr[0]), .s_data(s_data[0]), .s_wren(s_wren[0]),
    .secret_key(key[0]), .busy(busy[0]), .found(found[0]), .failed(failed[0])
  );

  rc4_phase_sequencer #(.KEY_MAX(24'd2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]),
    .init_start(st[1][0]), .shuf_start(st[1][1]), .dec_start(st[1][2]),
    .init_finish(finw[1][0]), .shuf_finish(finw[1][1]), .dec_finish(finw[1][2]),
    .init_ack(ak[1][0]), .shuf_ack(ak[1][1]), .dec_ack(ak[1][2]),
    .dec_key_ok(key_ok[1]),
    .init_addr(ea[1][0]), .init_data(ed[1][0]), .init_wren(ew[1][0]),
    .shuf_addr(ea[1][1]), .shuf_data(ed[1][1]), .shuf_wren(ew[1][1]),
    .dec_addr(ea[1][2]), .dec_data(ed[1][2]), .dec_wren(ew[1][2]),
    .s_addr(s_addr[1]), .s_data(s_data[1]), .s_wren(s_wren[1]),
    .secret_key(key[1]), .busy(busy[1]), .found(found[1]), .failed(failed[1])
  );

  // kind: 0 init_start, 1 shuf_start, 2 dec_start, 3 found, 4 failed
  typedef struct {
    int          kind;
    logic [23:0] k;
  } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int u, input int kind, input logic [23:0] k);
    ev_t e;
    e.kind = kind;
    e.k    = k;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic expect_round(input int u, input logic [23:0] k);
    for (int p = 0; p < 3; p++) expect_ev(u, p, k);
  endtask

  task automatic observe(input int u, input int kind, input logic [23:0] k);
    ev_t e;
    tests++;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_event u%0d: got kind %0d key %0h, expected none", u, kind, k);
    end else begin
      if (u == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (e.kind != kind || e.k !== k) begin
        fails++;
        $display("FAIL event_order u%0d: got kind %0d key %0h, expected kind %0d key %0h",
                 u, kind, k, e.kind, e.k);
      end
    end
  endtask

  logic found_p [2];
  logic failed_p [2];
  logic have_ack [2];
  int   ack_cyc [2];

  // Monitor: pops the scoreboard on every start pulse and search result edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        have_ack[u] = 1'b0;
      end else begin
        for (int e = 0; e < 3; e++) if (st[u][e]) observe(u, e, key[u]);
        if (st[u][0] && have_ack[u]) chk("dec_ack_to_init_start", 32'(cyc - ack_cyc[u]), 32'd2);
        if (st[u][0]) have_ack[u] = 1'b0;
        if (ak[u][2]) begin
          have_ack[u] = 1'b1;
          ack_cyc[u]  = cyc;
        end
        if (found[u] && !found_p[u])   observe(u, 3, key[u]);
        if (failed[u] && !failed_p[u]) observe(u, 4, key[u]);
        if (found[u] || failed[u]) have_ack[u] = 1'b0;
      end
      found_p[u]  = found[u];
      failed_p[u] = failed[u];
    end
  end

  task automatic pulse_start(input int u);
    @(posedge clk) #1 start_i[u] = 1'b1;
    @(posedge clk) #1 start_i[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int budget);
    int n = 0;
    while (busy[u] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy[u]) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_start(input int u, input int e, input int budget);
    int n = 0;
    @(negedge clk);
    while (!st[u][e] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!st[u][e]) chk("wait_start_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i[0] = 1'b0; start_i[1] = 1'b0;
    xfin[0] = 1'b0;    xfin[1] = 1'b0;
    ok_en[0] = 1'b1;   ok_en[1] = 1'b0;
    ok_key[0] = 24'd0; ok_key[1] = 24'd0;
    ovr = 1'b0;
    for (int u = 0; u < 2; u++) begin
      found_p[u] = 1'b0; failed_p[u] = 1'b0; have_ack[u] = 1'b0; ack_cyc[u] = 0;
    end

    #12;
    chk("rst_busy",   {31'd0, busy[0]},   32'd0);
    chk("rst_found",  {31'd0, found[0]},  32'd0);
    chk("rst_failed", {31'd0, failed[0]}, 32'd0);
    chk("rst_key",    {8'd0, key[0]},     32'd0);
    chk("rst_starts", {29'd0, st[0]},     32'd0);
    chk("rst_acks",   {29'd0, ak[0]},     32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_addr", {24'd0, s_addr[0]}, 32'd0);
    chk("idle_s_data", {24'd0, s_data[0]}, 32'd0);
    chk("idle_s_wren", {31'd0, s_wren[0]}, 32'd0);

    // Hit on key 0, plus a stray shuffler write during INIT_RUN.
    expect_round(0, 24'd0);
    expect_ev(0, 3, 24'd0);
    pulse_start(0);
    @(negedge clk);
    chk("first_init_start", {31'd0, st[0][0]}, 32'd1);
    chk("busy_after_start", {31'd0, busy[0]},  32'd1);
    ovr = 1'b1;
    #1;
    chk("stray_wren_blocked", {31'd0, s_wren[0]}, 32'd0);
    chk("stray_addr_blocked", {24'd0, s_addr[0]}, 32'h40);
    @(negedge clk);
    chk("init_wren_routed", {31'd0, s_wren[0]}, 32'd1);
    chk("init_addr_routed", {24'd0, s_addr[0]}, 32'h40);
    chk("init_data_routed", {24'd0, s_data[0]}, 32'hA0);
    ovr = 1'b0;
    wait_idle(0, 300);
    chk("t1_found",  {31'd0, found[0]},  32'd1);
    chk("t1_failed", {31'd0, failed[0]}, 32'd0);
    chk("t1_key",    {8'd0, key[0]},     32'd0);

    // Restart from FOUND; hit on key 3 after four rounds.
    ok_key[0] = 24'd3;
    for (int k = 0; k < 4; k++) expect_round(0, 24'(k));
    expect_ev(0, 3, 24'd3);
    pulse_start(0);
    @(negedge clk);
    chk("restart_found_clr", {31'd0, found[0]}, 32'd0);
    chk("restart_key_zero",  {8'd0, key[0]},    32'd0);
    chk("restart_init",      {31'd0, st[0][0]}, 32'd1);
    wait_idle(0, 600);
    chk("t2_found", {31'd0, found[0]}, 32'd1);
    chk("t2_key",   {8'd0, key[0]},    32'd3);

    // KEY_MAX=2 with no hit: three rounds then FAILED.
    for (int k = 0; k < 3; k++) expect_round(1, 24'(k));
    expect_ev(1, 4, 24'd2);
    pulse_start(1);
    wait_idle(1, 600);
    repeat (20) @(negedge clk);
    chk("t3_failed", {31'd0, failed[1]}, 32'd1);
    chk("t3_found",  {31'd0, found[1]},  32'd0);
    chk("t3_key",    {8'd0, key[1]},     32'd2);
    chk("t3_no_extra_rounds", 32'(q1.size()), 32'd0);

    // Stray init finish during SHUF_RUN, then reset during DEC_RUN.
    ok_en[0] = 1'b0;
    expect_round(0, 24'd0);
    pulse_start(0);
    wait_start(0, 1, 100);
    xfin[0] = 1'b1;
    @(negedge clk);
    xfin[0] = 1'b0;
    chk("stray_finish_no_ack", {31'd0, ak[0][0]}, 32'd0);
    @(negedge clk);
    chk("stray_finish_no_ack2", {31'd0, ak[0][0]},      32'd0);
    chk("shuf_still_owns",      {30'd0, s_addr[0][7:6]}, 32'd2);
    wait_start(0, 2, 100);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   {31'd0, busy[0]},   32'd0);
    chk("midrst_s_wren", {31'd0, s_wren[0]}, 32'd0);
    chk("midrst_s_addr", {24'd0, s_addr[0]}, 32'd0);
    chk("midrst_key",    {8'd0, key[0]},     32'd0);
    chk("midrst_acks",   {29'd0, ak[0]},     32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle",  {31'd0, busy[0]}, 32'd0);
    chk("scoreboard_a_empty", 32'(q0.size()), 32'd0);
    chk("scoreboard_b_empty", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
